// File: rtl/pulse_sequencer.sv
// Trigger-driven scheduler that walks NUM_CH pulse channels, applying a programmed delay then a start pulse of programmed width.
// Optional macro SEQ_BURST_EN adds a burst-repeat register at config address 2*NUM_CH+1.
module pulse_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 35,
    parameter int ADDR_W = 5
) (
    input  logic              clk_Seq,
    input  logic              rst_Seq,
    input  logic              src_int,
    input  logic              trig_ext,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic [NUM_CH-1:0] ch_start,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [7:0]        trig_miss
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PER_ADDR = ADDR_W'(2 * NUM_CH);
`ifdef SEQ_BURST_EN
    localparam logic [ADDR_W-1:0] BURST_ADDR = ADDR_W'(2 * NUM_CH + 1);
    localparam logic [ADDR_W-1:0] TOP_ADDR   = BURST_ADDR;
`else
    localparam logic [ADDR_W-1:0] TOP_ADDR   = PER_ADDR;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NUM_CH-1:0]  ch_start_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               cfg_err_reg;
    logic [7:0]         trig_miss_reg;

    logic [CNT_W-1:0]   dly_reg [NUM_CH];
    logic [CNT_W-1:0]   dur_reg [NUM_CH];
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   per_cnt_reg;

    logic               sync1_reg;
    logic               sync2_reg;
    logic               sync3_reg;
    logic               ext_edge_reg;

    logic               int_tick;
    logic               trig_sel;
    logic               is_idle;
    logic               accept;
    logic               addr_ok;
    logic               wr_ok;
    logic               wr_per;
    logic [NUM_CH-1:0]  wr_dly;
    logic [NUM_CH-1:0]  wr_dur;
    logic [CNT_W-1:0]   cur_dly;
    logic [CNT_W-1:0]   cur_dur;

`ifdef SEQ_BURST_EN
    logic [7:0]         burst_reg;
    logic [7:0]         pass_reg;
    logic               wr_burst;
`endif

    // External trigger: two-flop synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge clk_Seq) begin
        if (rst_Seq) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            sync3_reg    <= 1'b0;
            ext_edge_reg <= 1'b0;
        end else begin
            sync1_reg    <= trig_ext;
            sync2_reg    <= sync1_reg;
            sync3_reg    <= sync2_reg;
            ext_edge_reg <= sync2_reg & ~sync3_reg;
        end
    end

    assign int_tick = (period_reg != '0) && (per_cnt_reg == period_reg - ONE);
    assign trig_sel = src_int ? int_tick : ext_edge_reg;
    assign is_idle  = (state_reg == S_IDLE);
    assign accept   = trig_sel && is_idle;

    // A trigger accepted this cycle makes the block busy, so a coincident write loses.
    assign addr_ok  = (cfg_addr <= TOP_ADDR);
    assign wr_ok    = cfg_we && is_idle && !trig_sel && addr_ok;
    assign wr_per   = wr_ok && (cfg_addr == PER_ADDR);
`ifdef SEQ_BURST_EN
    assign wr_burst = wr_ok && (cfg_addr == BURST_ADDR);
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
            assign wr_dly[gi] = wr_ok && (cfg_addr == ADDR_W'(2 * gi));
            assign wr_dur[gi] = wr_ok && (cfg_addr == ADDR_W'(2 * gi + 1));
        end
    endgenerate

    assign cur_dly = dly_reg[idx_reg];
    assign cur_dur = dur_reg[idx_reg];

    always_ff @(posedge clk_Seq) begin
        if (rst_Seq) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dly_reg[i] <= '0;
                dur_reg[i] <= '0;
            end
            period_reg <= '0;
`ifdef SEQ_BURST_EN
            burst_reg  <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_dly[i]) dly_reg[i] <= cfg_data;
                if (wr_dur[i]) dur_reg[i] <= cfg_data;
            end
            if (wr_per) period_reg <= cfg_data;
`ifdef SEQ_BURST_EN
            if (wr_burst) burst_reg <= cfg_data[7:0];
`endif
        end
    end

    // Period counter free-runs independently of the sequencer state.
    always_ff @(posedge clk_Seq) begin
        if (rst_Seq) begin
            per_cnt_reg   <= '0;
            trig_miss_reg <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            if (wr_per || (period_reg == '0) || int_tick) begin
                per_cnt_reg <= '0;
            end else begin
                per_cnt_reg <= per_cnt_reg + ONE;
            end
            if (trig_sel && !is_idle && (trig_miss_reg != 8'hFF)) begin
                trig_miss_reg <= trig_miss_reg + 8'd1;
            end
            cfg_err_reg <= cfg_we && !wr_ok;
        end
    end

    always_ff @(posedge clk_Seq) begin
        if (rst_Seq) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            ch_start_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef SEQ_BURST_EN
            pass_reg     <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
`ifdef SEQ_BURST_EN
                        pass_reg  <= '0;
`endif
                        state_reg <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (cnt_reg == cur_dly) begin
                        cnt_reg <= '0;
                        if (cur_dur != '0) begin
                            ch_start_reg <= NUM_CH'(1) << idx_reg;
                            state_reg    <= S_PULSE;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + ONE;
                    end
                end
                S_PULSE: begin
                    cnt_reg <= cnt_reg + ONE;
                    if (cnt_reg == cur_dur - ONE) begin
                        ch_start_reg <= '0;
                        state_reg    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ch_start_reg <= '0;
                    cnt_reg      <= '0;
                    if (idx_reg == LAST_IDX) begin
`ifdef SEQ_BURST_EN
                        if (pass_reg != burst_reg) begin
                            pass_reg  <= pass_reg + 8'd1;
                            idx_reg   <= '0;
                            state_reg <= S_DELAY;
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_DONE;
                        end
`else
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
`endif
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= S_DELAY;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_start  = ch_start_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cfg_err   = cfg_err_reg;
    assign trig_miss = trig_miss_reg;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: hand-computed timing of channel pulses, done, busy, cfg_err and trig_miss.
module tb_pulse_sequencer;

    logic        clk_Seq = 1'b0;
    logic        rst_Seq = 1'b1;
    logic        src_int = 1'b0;
    logic        trig_ext = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [34:0] cfg_data = '0;
    logic [3:0]  ch_start;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [7:0]  trig_miss;

    pulse_sequencer #(.NUM_CH(4), .CNT_W(35), .ADDR_W(5)) dut (
        .clk_Seq  (clk_Seq),
        .rst_Seq  (rst_Seq),
        .src_int  (src_int),
        .trig_ext (trig_ext),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .ch_start (ch_start),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .trig_miss(trig_miss)
    );

    always #5 clk_Seq = ~clk_Seq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hi_cnt [4];
    int first_hi [4];
    int done_cnt;
    int last_done;
    int viol;
    int rise_n;
    int rise_t [16];
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d", tag, got);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i]   = 0;
            first_hi[i] = -1;
        end
        done_cnt  = 0;
        last_done = -1;
        viol      = 0;
        rise_n    = 0;
    endtask

    // Advance n cycles, sampling the outputs at each falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_Seq);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (ch_start[i]) begin
                    if (hi_cnt[i] == 0) first_hi[i] = cyc;
                    hi_cnt[i]++;
                end
            end
            if ($countones(ch_start) > 1) viol++;
            if (done) begin
                done_cnt++;
                last_done = cyc;
            end
            if (busy && !busy_prev) begin
                if (rise_n < 16) rise_t[rise_n] = cyc;
                rise_n++;
            end
            busy_prev = busy;
        end
    endtask

    task automatic cfg_write(input int addr, input longint data, output logic err);
        cfg_addr = addr[4:0];
        cfg_data = 35'(data);
        cfg_we   = 1'b1;
        step(1);
        err    = cfg_err;
        cfg_we = 1'b0;
    endtask

    task automatic fire(output int t0);
        clear_mon();
        t0       = cyc;
        trig_ext = 1'b1;
        step(5);
        trig_ext = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            step(1);
            k++;
        end
        check("idle_wait", busy, 0);
        step(3);
    endtask

    initial begin
        int t0;
        int c;
        logic err;
        logic err_acc;
        int dly [4] = '{2, 0, 5, 1};
        int dur [4] = '{3, 1, 0, 4};

        clear_mon();
        step(2);
        rst_Seq = 1'b0;
        step(1);
        check("rst_ch_start", ch_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_trig_miss", trig_miss, 0);

        // Internal source with period 0 never fires.
        src_int = 1'b1;
        clear_mon();
        step(1000);
        check("per0_pulses", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("per0_busy", rise_n, 0);
        src_int = 1'b0;
        step(2);

        err_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_write(2 * i, dly[i], err);
            err_acc |= err;
            cfg_write(2 * i + 1, dur[i], err);
            err_acc |= err;
        end
        check("cfg_ok", err_acc, 0);

        fire(t0);
        step(35);
        check("seq_hi0", hi_cnt[0], 3);
        check("seq_hi1", hi_cnt[1], 1);
        check("seq_hi2", hi_cnt[2], 0);
        check("seq_hi3", hi_cnt[3], 4);
        check("seq_first0", first_hi[0] - t0, 7);
        check("seq_first1", first_hi[1] - t0, 12);
        check("seq_first3", first_hi[3] - t0, 23);
        check("seq_done_n", done_cnt, 1);
        check("seq_done_t", last_done - t0, 28);
        check("seq_onehot", viol, 0);
        check("seq_busy_end", busy, 0);

        cfg_write(0, 0, err);
        cfg_write(1, 1, err);
        fire(t0);
        step(35);
        check("d0_first0", first_hi[0] - t0, 5);
        check("d0_hi0", hi_cnt[0], 1);

        // Write while busy is dropped; delay[0] must stay 0.
        fire(t0);
        cfg_write(0, 77, err);
        check("busy_wr_err", err, 1);
        step(35);
        fire(t0);
        step(35);
        check("busy_wr_kept", first_hi[0] - t0, 5);
        cfg_write(10, 5, err);
        check("bad_addr_err", err, 1);
        cfg_write(9, 0, err);
`ifdef SEQ_BURST_EN
        check("addr9_err", err, 0);
`else
        check("addr9_err", err, 1);
`endif
        check("miss_before_int", trig_miss, 0);

        // Period 100: one sequence per 100 cycles, none dropped.
        cfg_write(0, 2, err);
        cfg_write(1, 3, err);
        c = cyc;
        cfg_write(8, 100, err);
        src_int = 1'b1;
        clear_mon();
        step(1000);
        check("p100_rises", rise_n, 10);
        check("p100_first", rise_t[0] - c, 101);
        check("p100_gap_a", rise_t[1] - rise_t[0], 100);
        check("p100_gap_b", rise_t[9] - rise_t[8], 100);
        check("p100_done_n", done_cnt, 9);
        check("p100_miss", trig_miss, 0);

        src_int = 1'b0;
        wait_idle();
        cfg_write(8, 10, err);
        src_int = 1'b1;
        step(300);
        check("p10_miss", trig_miss, 20);
        step(4000);
        check("p10_miss_sat", trig_miss, 255);
        src_int = 1'b0;
        wait_idle();
        cfg_write(8, 0, err);
        check("per_off_err", err, 0);

`ifdef SEQ_BURST_EN
        cfg_write(9, 2, err);
        fire(t0);
        step(85);
        check("burst_hi0", hi_cnt[0], 9);
        check("burst_hi3", hi_cnt[3], 12);
        check("burst_done_n", done_cnt, 1);
        check("burst_done_t", last_done - t0, 76);
        check("burst_rises", rise_n, 1);
`endif

        // Reset during channel 1's pulse aborts and clears every register.
        fire(t0);
        begin
            int k = 0;
            while (!ch_start[1] && k < 40) begin
                step(1);
                k++;
            end
        end
        check("ch1_seen", ch_start[1], 1);
        rst_Seq = 1'b1;
        step(1);
        check("abort_ch_start", ch_start, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_trig_miss", trig_miss, 0);
        rst_Seq = 1'b0;
        step(2);
        fire(t0);
        step(20);
        check("zero_pulses", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("zero_done_n", done_cnt, 1);
        check("zero_done_t", last_done - t0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
